// File: rtl/armleo_axi_wr_sched.sv
// Round-robin write-path scheduler: owns the shared AW/W/B channel for one full
// write transaction and flags W beat counts that disagree with the captured awlen.
module armleo_axi_wr_sched #(
    parameter int HOST_NUMBER = 3,
    localparam int HOST_NUMBER_CLOG2 = $clog2(HOST_NUMBER)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [HOST_NUMBER-1:0]       upstream_axi_awvalid,
    input  logic                         downstream_axi_awvalid,
    input  logic                         downstream_axi_awready,
    input  logic [7:0]                   downstream_axi_awlen,
    input  logic                         downstream_axi_wvalid,
    input  logic                         downstream_axi_wready,
    input  logic                         downstream_axi_wlast,
    input  logic                         downstream_axi_bvalid,
    input  logic                         downstream_axi_bready,
    output logic [HOST_NUMBER-1:0]       select,
    output logic [HOST_NUMBER_CLOG2-1:0] select_idx,
    output logic                         select_valid,
    output logic                         wlast_error,
    output logic [1:0]                   state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                       state_r, state_nxt_s;
    logic [HOST_NUMBER-1:0]       select_r, select_nxt_s;
    logic [HOST_NUMBER_CLOG2-1:0] select_idx_r, select_idx_nxt_s;
    logic                         select_valid_r, select_valid_nxt_s;
    logic                         wlast_error_r, wlast_error_nxt_s;
    logic [HOST_NUMBER_CLOG2-1:0] rr_ptr_r, rr_ptr_nxt_s;
    logic [8:0]                   beat_cnt_r, beat_cnt_nxt_s;
    logic                         w_done_r, w_done_nxt_s;
    logic [8:0]                   expected_r, expected_nxt_s;
    logic                         err_fired_r, err_fired_nxt_s;

    logic                         aw_hs_s, w_hs_s, wl_hs_s, b_hs_s;
    logic [8:0]                   cnt_inc_s, awlen_plus1_s;
    logic                         win_found_s;
    logic [HOST_NUMBER_CLOG2-1:0] win_idx_s;

    assign aw_hs_s       = downstream_axi_awvalid & downstream_axi_awready;
    assign w_hs_s        = downstream_axi_wvalid & downstream_axi_wready;
    assign wl_hs_s       = w_hs_s & downstream_axi_wlast;
    assign b_hs_s        = downstream_axi_bvalid & downstream_axi_bready;
    assign cnt_inc_s     = beat_cnt_r + {8'd0, w_hs_s};
    assign awlen_plus1_s = {1'b0, downstream_axi_awlen} + 9'd1;

    // Round-robin search: first requester at or after the pointer, wrapping at HOST_NUMBER.
    always_comb begin
        int                           cand_v;
        logic [HOST_NUMBER_CLOG2-1:0] cand_idx_v;
        cand_v      = 0;
        cand_idx_v  = {HOST_NUMBER_CLOG2{1'b0}};
        win_found_s = 1'b0;
        win_idx_s   = {HOST_NUMBER_CLOG2{1'b0}};
        for (int i = 0; i < HOST_NUMBER; i++) begin
            cand_v = int'(rr_ptr_r) + i;
            if (cand_v >= HOST_NUMBER) begin
                cand_v = cand_v - HOST_NUMBER;
            end else begin
                cand_v = cand_v;
            end
            cand_idx_v = HOST_NUMBER_CLOG2'(cand_v);
            if (!win_found_s && upstream_axi_awvalid[cand_idx_v]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_idx_v;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state, grant and beat-count checking.
    always_comb begin
        state_nxt_s        = state_r;
        select_nxt_s       = select_r;
        select_idx_nxt_s   = select_idx_r;
        select_valid_nxt_s = select_valid_r;
        wlast_error_nxt_s  = 1'b0;
        rr_ptr_nxt_s       = rr_ptr_r;
        beat_cnt_nxt_s     = beat_cnt_r;
        w_done_nxt_s       = w_done_r;
        expected_nxt_s     = expected_r;
        err_fired_nxt_s    = err_fired_r;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    select_nxt_s       = HOST_NUMBER'(1) << win_idx_s;
                    select_idx_nxt_s   = win_idx_s;
                    select_valid_nxt_s = 1'b1;
                    rr_ptr_nxt_s       = (win_idx_s == HOST_NUMBER_CLOG2'(HOST_NUMBER - 1)) ?
                                         {HOST_NUMBER_CLOG2{1'b0}} : win_idx_s + HOST_NUMBER_CLOG2'(1);
                    beat_cnt_nxt_s     = 9'd0;
                    w_done_nxt_s       = 1'b0;
                    expected_nxt_s     = 9'd0;
                    err_fired_nxt_s    = 1'b0;
                    state_nxt_s        = ADDR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADDR: begin
                beat_cnt_nxt_s = cnt_inc_s;
                w_done_nxt_s   = w_done_r | wl_hs_s;
                if (aw_hs_s) begin
                    expected_nxt_s = awlen_plus1_s;
                    // Beats that arrived before AW are judged only once the length is known.
                    if (w_done_r || wl_hs_s) begin
                        if ((cnt_inc_s != awlen_plus1_s) && !err_fired_r) begin
                            wlast_error_nxt_s = 1'b1;
                            err_fired_nxt_s   = 1'b1;
                        end else begin
                            wlast_error_nxt_s = 1'b0;
                        end
                        state_nxt_s = RESP;
                    end else begin
                        if ((cnt_inc_s >= awlen_plus1_s) && !err_fired_r) begin
                            wlast_error_nxt_s = 1'b1;
                            err_fired_nxt_s   = 1'b1;
                        end else begin
                            wlast_error_nxt_s = 1'b0;
                        end
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = ADDR;
                end
            end
            DATA: begin
                beat_cnt_nxt_s = cnt_inc_s;
                if (wl_hs_s) begin
                    w_done_nxt_s = 1'b1;
                    if ((cnt_inc_s != expected_r) && !err_fired_r) begin
                        wlast_error_nxt_s = 1'b1;
                        err_fired_nxt_s   = 1'b1;
                    end else begin
                        wlast_error_nxt_s = 1'b0;
                    end
                    state_nxt_s = RESP;
                end else if (w_hs_s && (cnt_inc_s >= expected_r) && !err_fired_r) begin
                    wlast_error_nxt_s = 1'b1;
                    err_fired_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            RESP: begin
                if (b_hs_s) begin
                    select_nxt_s       = {HOST_NUMBER{1'b0}};
                    select_valid_nxt_s = 1'b0;
                    beat_cnt_nxt_s     = 9'd0;
                    w_done_nxt_s       = 1'b0;
                    err_fired_nxt_s    = 1'b0;
                    state_nxt_s        = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                select_nxt_s       = {HOST_NUMBER{1'b0}};
                select_valid_nxt_s = 1'b0;
                beat_cnt_nxt_s     = 9'd0;
                w_done_nxt_s       = 1'b0;
                err_fired_nxt_s    = 1'b0;
                state_nxt_s        = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            select_r       <= {HOST_NUMBER{1'b0}};
            select_idx_r   <= {HOST_NUMBER_CLOG2{1'b0}};
            select_valid_r <= 1'b0;
            wlast_error_r  <= 1'b0;
            rr_ptr_r       <= {HOST_NUMBER_CLOG2{1'b0}};
            beat_cnt_r     <= 9'd0;
            w_done_r       <= 1'b0;
            expected_r     <= 9'd0;
            err_fired_r    <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            select_r       <= select_nxt_s;
            select_idx_r   <= select_idx_nxt_s;
            select_valid_r <= select_valid_nxt_s;
            wlast_error_r  <= wlast_error_nxt_s;
            rr_ptr_r       <= rr_ptr_nxt_s;
            beat_cnt_r     <= beat_cnt_nxt_s;
            w_done_r       <= w_done_nxt_s;
            expected_r     <= expected_nxt_s;
            err_fired_r    <= err_fired_nxt_s;
        end
    end

    assign select       = select_r;
    assign select_idx   = select_idx_r;
    assign select_valid = select_valid_r;
    assign wlast_error  = wlast_error_r;
    assign state        = state_r;

endmodule
